// File: rtl/d_exc.sv
// D-stage exception resolve and D/E exception-code register.
// Define D_EXC_SYSCALL_EN to add the Syscall input (code 8, below RI).
module d_exc (
  input  logic       clk,
  input  logic       reset,
  input  logic       Default,
  input  logic [6:2] ExcCode_in,
  input  logic       stall,
  input  logic       clr,
`ifdef D_EXC_SYSCALL_EN
  input  logic       Syscall,
`endif
  output logic [6:2] ExcCode_D,
  output logic [6:2] ExcCode_out,
  output logic       exc_valid
);

  localparam logic [6:2] excNone = 5'd0;
  localparam logic [6:2] excSys  = 5'd8;
  localparam logic [6:2] excRi   = 5'd10;

  // F-stage codes are older and win over anything found in D
  always_comb begin
    ExcCode_D = excNone;
    if (ExcCode_in != excNone) begin
      ExcCode_D = ExcCode_in;
    end else if (Default) begin
      ExcCode_D = excRi;
`ifdef D_EXC_SYSCALL_EN
    end else if (Syscall) begin
      ExcCode_D = excSys;
`endif
    end else begin
      ExcCode_D = excNone;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExcCode_out <= excNone;
    end else if (clr) begin
      ExcCode_out <= excNone;
    end else if (!stall) begin
      ExcCode_out <= ExcCode_D;
    end
  end

  assign exc_valid = (ExcCode_out != excNone);

`ifndef D_EXC_SYSCALL_EN
  logic unusedSys;
  assign unusedSys = ^excSys;
`endif

endmodule

// File: tb/tb_d_exc.sv
// Directed bench for d_exc.
// Define D_EXC_SYSCALL_EN to also cover the Syscall build.
module tb_d_exc;

  logic       clk;
  logic       reset;
  logic       Default;
  logic [6:2] ExcCode_in;
  logic       stall;
  logic       clr;
`ifdef D_EXC_SYSCALL_EN
  logic       Syscall;
`endif
  logic [6:2] ExcCode_D;
  logic [6:2] ExcCode_out;
  logic       exc_valid;

  int nChecks = 0;
  int nFails  = 0;

  d_exc dut (
    .clk        (clk),
    .reset      (reset),
    .Default    (Default),
    .ExcCode_in (ExcCode_in),
    .stall      (stall),
    .clr        (clr),
`ifdef D_EXC_SYSCALL_EN
    .Syscall    (Syscall),
`endif
    .ExcCode_D  (ExcCode_D),
    .ExcCode_out(ExcCode_out),
    .exc_valid  (exc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [6:0] obs,
                       input logic [6:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    Default    = 1'b1;
    ExcCode_in = 5'd0;
    stall      = 1'b0;
    clr        = 1'b0;
`ifdef D_EXC_SYSCALL_EN
    Syscall    = 1'b0;
`endif
    #1;
    check("rst_out", {2'b0, ExcCode_out}, 7'd0);
    check("rst_valid", {6'b0, exc_valid}, 7'd0);
    check("rst_d_comb", {2'b0, ExcCode_D}, 7'd10);
    tick();
    check("rst_hold_edge", {2'b0, ExcCode_out}, 7'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ri_d", {2'b0, ExcCode_D}, 7'd10);
    tick();
    check("ri_out", {2'b0, ExcCode_out}, 7'd10);
    check("ri_valid", {6'b0, exc_valid}, 7'd1);

    Default = 1'b0;
    #1;
    check("idle_d", {2'b0, ExcCode_D}, 7'd0);
    tick();
    check("idle_out", {2'b0, ExcCode_out}, 7'd0);
    check("idle_valid", {6'b0, exc_valid}, 7'd0);

    ExcCode_in = 5'd4;
    Default    = 1'b1;
    #1;
    check("prio_d", {2'b0, ExcCode_D}, 7'd4);
    tick();
    check("prio_out", {2'b0, ExcCode_out}, 7'd4);

    ExcCode_in = 5'd0;
    tick();
    check("pre_stall_out", {2'b0, ExcCode_out}, 7'd10);
    stall      = 1'b1;
    ExcCode_in = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out", {2'b0, ExcCode_out}, 7'd10);
      check("stall_d", {2'b0, ExcCode_D}, 7'd4);
    end

    ExcCode_in = 5'd0;
    clr        = 1'b1;
    #1;
    check("both_d", {2'b0, ExcCode_D}, 7'd10);
    tick();
    check("both_out", {2'b0, ExcCode_out}, 7'd0);

    stall = 1'b0;
    clr   = 1'b0;
    tick();
    check("reload_out", {2'b0, ExcCode_out}, 7'd10);
    clr = 1'b1;
    tick();
    check("clr_out", {2'b0, ExcCode_out}, 7'd0);
    clr = 1'b0;

    ExcCode_in = 5'd31;
    #1;
    check("pass31_d", {2'b0, ExcCode_D}, 7'd31);
    tick();
    check("pass31_out", {2'b0, ExcCode_out}, 7'd31);
    ExcCode_in = 5'd12;
    tick();
    check("ov_out", {2'b0, ExcCode_out}, 7'd12);

    ExcCode_in = 5'd0;
    Default    = 1'b1;
    tick();
    check("pre_rst_out", {2'b0, ExcCode_out}, 7'd10);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", {2'b0, ExcCode_out}, 7'd0);
    check("async_rst_valid", {6'b0, exc_valid}, 7'd0);
    check("async_rst_d", {2'b0, ExcCode_D}, 7'd10);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_out", {2'b0, ExcCode_out}, 7'd10);

`ifdef D_EXC_SYSCALL_EN
    Default = 1'b0;
    Syscall = 1'b1;
    #1;
    check("sys_d", {2'b0, ExcCode_D}, 7'd8);
    tick();
    check("sys_out", {2'b0, ExcCode_out}, 7'd8);
    Default = 1'b1;
    #1;
    check("sys_ri_d", {2'b0, ExcCode_D}, 7'd10);
    ExcCode_in = 5'd5;
    #1;
    check("sys_ades_d", {2'b0, ExcCode_D}, 7'd5);
    Syscall    = 1'b0;
    ExcCode_in = 5'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/d_exc.md
D_EXC -- requirements
Module: d_exc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Default, input, 1 bit: 1 = D-stage decoder matched no legal instruction (reserved instruction).
REQ-004 SHALL have port ExcCode_in, input, bits [6:2]: exception code carried in from F stage; 0 = none.
REQ-005 SHALL have port stall, input, 1 bit: 1 = hold the stage register.
REQ-006 SHALL have port clr, input, 1 bit: 1 = flush; load a bubble into the stage register.
REQ-007 SHALL have port ExcCode_D, output, bits [6:2]: combinational D-stage resolved exception code.
REQ-008 SHALL have port ExcCode_out, output, bits [6:2]: registered exception code presented to E stage.
REQ-009 SHALL have port exc_valid, output, 1 bit: 1 when ExcCode_out != 0.

Function
REQ-010 SHALL use these codes: 0 = none, 4 = AdEL, 5 = AdES, 8 = Syscall, 10 = RI, 12 = Ov.
REQ-011 SHALL resolve ExcCode_D by fixed priority, combinationally, with zero latency:
- ExcCode_in != 0 gives ExcCode_in, passed unchanged.
- Otherwise, Default = 1 gives 10.
- Otherwise, 0.
REQ-012 SHALL pass any nonzero ExcCode_in through unchanged, including codes not listed in REQ-010; no validation is performed.
REQ-013 SHALL update ExcCode_out on each rising clk edge as follows:
- clr = 1 loads 0.
- Otherwise, stall = 1 holds the current value.
- Otherwise, loads ExcCode_D.
REQ-014 SHALL give clr priority over stall when both are asserted in the same cycle.
REQ-015 SHALL make exc_valid a combinational function of ExcCode_out only, with no extra cycle of latency.
REQ-016 SHALL let ExcCode_D follow the inputs while stall = 1, while ExcCode_out stays frozen.
REQ-017 SHALL keep ExcCode_out fixed between clock edges, with no glitching.

Reset
REQ-018 SHALL, while reset = 1, force ExcCode_out = 0 and exc_valid = 0 immediately, independent of clk.
REQ-019 SHALL override clr, stall and all data inputs with reset.
REQ-020 SHALL resume normal register updates on the first rising clk edge after reset deasserts.
REQ-021 SHALL NOT let reset affect ExcCode_D, which remains purely combinational.

Configuration
REQ-022 SHALL, with macro D_EXC_SYSCALL_EN defined, add input port Syscall (1 bit).
REQ-023 SHALL, with D_EXC_SYSCALL_EN defined, extend the priority of REQ-011 as follows:
- ExcCode_in != 0 gives ExcCode_in.
- Otherwise, Default gives 10.
- Otherwise, Syscall gives 8.
- Otherwise, 0.
REQ-024 SHALL, with D_EXC_SYSCALL_EN undefined, omit the Syscall port and behave exactly per REQ-011.

Verification
REQ-025 SHALL cover reset: assert reset mid-cycle with ExcCode_out = 10 -> ExcCode_out = 0 and exc_valid = 0 at once, without a clock edge.
REQ-026 SHALL cover basic RI and idle:
- ExcCode_in = 0, Default = 1, stall = 0, clr = 0, one edge -> ExcCode_D = 10 immediately and ExcCode_out = 10 after the edge.
- Then Default = 0, next edge -> ExcCode_out = 0.
REQ-027 SHALL cover priority: ExcCode_in = 4 with Default = 1 -> ExcCode_D = 4 and, after an edge, ExcCode_out = 4 (the F-stage code wins over RI).
REQ-028 SHALL cover stall: ExcCode_out = 10, stall = 1, inputs changed to ExcCode_in = 4 for 3 edges -> ExcCode_out stays 10 and ExcCode_D = 4.
REQ-029 SHALL cover simultaneous controls: stall = 1 and clr = 1 with ExcCode_D = 10, one edge -> ExcCode_out = 0.
REQ-030 SHALL cover the macro build: with D_EXC_SYSCALL_EN defined, Syscall = 1 and Default = 0 -> ExcCode_D = 8; adding Default = 1 -> ExcCode_D = 10.
